// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency, single-ported memory between
// the instruction-fetch port and the MEM-stage data port. One access is in
// flight at a time, data accesses win ties, and the pipeline is stalled
// while a requester is waiting for its completion pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | sample requests; on a grant latch owner/addr/we/wdata
// ISSUE | mem_cs pulse is on the memory bus; load latency down-counter
// WAIT  | count down; at terminal count mem_rdata is valid and captured
// RESP  | owner's ready pulse is visible; requests are not sampled
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o
);

  // ISSUE counts as the first latency cycle, so WAIT starts one short.
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              owner_dm, owner_dm_nxt;
  logic              req_we, req_we_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              mem_cs_nxt;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] if_rdata_nxt;
  logic [DATA_W-1:0] dm_rdata_nxt;
  logic              if_ready_nxt;
  logic              dm_ready_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode; every registered output is computed here
  always_comb begin
    state_nxt     = state;
    owner_dm_nxt  = owner_dm;
    req_we_nxt    = req_we;
    cnt_nxt       = cnt;
    mem_cs_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_ready_nxt  = 1'b0;
    dm_ready_nxt  = 1'b0;

    case (state)
      IDLE: begin
        // The memory-side registers double as the latched request, so the
        // issue pulse appears in the ISSUE cycle itself.
        if (dm_req) begin
          owner_dm_nxt  = 1'b1;
          req_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr;
          mem_wdata_nxt = dm_wdata;
          mem_cs_nxt    = 1'b1;
          mem_we_nxt    = dm_we;
          state_nxt     = ISSUE;
        end else if (if_req) begin
          owner_dm_nxt  = 1'b0;
          req_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_cs_nxt    = 1'b1;
          state_nxt     = ISSUE;
        end
      end

      ISSUE: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = WAIT;
      end

      WAIT: begin
        if (cnt == 4'd0) begin
          // Writes wait out the same latency but leave the rdata registers alone.
          if (!req_we) begin
            if (owner_dm) begin
              dm_rdata_nxt = mem_rdata;
            end else begin
              if_rdata_nxt = mem_rdata;
            end
          end
          if (owner_dm) begin
            dm_ready_nxt = 1'b1;
          end else begin
            if_ready_nxt = 1'b1;
          end
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dm  <= 1'b0;
      req_we    <= 1'b0;
      cnt       <= 4'd0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      owner_dm  <= owner_dm_nxt;
      req_we    <= req_we_nxt;
      cnt       <= cnt_nxt;
      mem_cs    <= mem_cs_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
      if_ready  <= if_ready_nxt;
      dm_ready  <= dm_ready_nxt;
    end
  end

  // Stall drops in the ready cycle so the pipeline advances exactly once.
  assign stall_o = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic from two independent requesters, checked by a scoreboard monitor.
// IF addresses live in 0x000-0x0FC and DM addresses in 0x100-0x1FC, so the
// expected read data of each port depends only on that port's own history.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam logic [31:0] K1 = 32'hA5A5_0F0F;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ready, dm_ready, mem_cs, mem_we, stall_o;

  logic if_req1, dm_req1, dm_we1;
  logic [31:0] if_addr1, dm_addr1, dm_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic if_ready1, dm_ready1, mem_cs1, mem_we1, stall1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] env_mem [0:127];
  logic [31:0] ref_mem [0:127];
  logic [31:0] last_dm_rdata;
  txn_t if_q[$];
  txn_t dm_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_o(stall_o)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
    .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_o(stall1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0b required %0b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory environment: returns read data exactly LAT cycles after mem_cs,
  // random garbage otherwise.
  int          rd_cd = 0;
  logic        rd_act = 1'b0;
  logic [31:0] rd_data;
  always @(negedge clk) begin
    if (rd_cd != 0) rd_cd = rd_cd - 1;
    if (rd_act && rd_cd == 0) begin
      mem_rdata = rd_data;
      rd_act = 1'b0;
    end else begin
      mem_rdata = $urandom;
    end
    if (mem_cs) begin
      if (mem_we) env_mem[mem_addr[8:2]] = mem_wdata;
      else begin
        rd_act = 1'b1;
        rd_cd = LAT;
        rd_data = env_mem[mem_addr[8:2]];
      end
    end
  end

  int          rd1_cd = 0;
  logic        rd1_act = 1'b0;
  logic [31:0] rd1_data;
  always @(negedge clk) begin
    if (rd1_cd != 0) rd1_cd = rd1_cd - 1;
    if (rd1_act && rd1_cd == 0) begin
      mem_rdata1 = rd1_data;
      rd1_act = 1'b0;
    end else begin
      mem_rdata1 = $urandom;
    end
    if (mem_cs1 && !mem_we1) begin
      rd1_act = 1'b1;
      rd1_cd = 1;
      rd1_data = mem_addr1 ^ K1;
    end
  end

  // Monitor: checks the memory bus and every completion against the scoreboard
  logic cs_pend = 1'b0, cs_if = 1'b0, prev_cs = 1'b0, dm_req_prev = 1'b0;
  int   last_cs_cyc = 0, prev_cs_cyc = 0;
  txn_t mt;
  always @(negedge clk) begin
    if (rst) begin
      cs_pend = 1'b0;
      prev_cs = 1'b0;
    end else begin
      chk1("stall", stall_o, (if_req & ~if_ready) | (dm_req & ~dm_ready));
      chk1("we_without_cs", mem_we & ~mem_cs, 1'b0);
      if (mem_cs) begin
        chk1("cs_one_cycle", prev_cs, 1'b0);
        chk1("cs_while_busy", cs_pend, 1'b0);
        prev_cs_cyc = last_cs_cyc;
        last_cs_cyc = cyc;
        cs_pend = 1'b1;
        cs_if = (mem_addr < 32'h100);
        if (cs_if) begin
          chk1("if_priority", dm_req_prev, 1'b0);
          if (if_q.size() == 0) chk1("if_cs_unexpected", 1'b1, 1'b0);
          else begin
            chk("if_mem_addr", mem_addr, if_q[0].addr);
            chk1("if_mem_we", mem_we, 1'b0);
          end
        end else begin
          if (dm_q.size() == 0) chk1("dm_cs_unexpected", 1'b1, 1'b0);
          else begin
            chk("dm_mem_addr", mem_addr, dm_q[0].addr);
            chk1("dm_mem_we", mem_we, dm_q[0].we);
            if (dm_q[0].we) chk("dm_mem_wdata", mem_wdata, dm_q[0].wdata);
          end
        end
      end
      if (if_ready | dm_ready) begin
        chk1("ready_exclusive", if_ready & dm_ready, 1'b0);
        chk1("ready_timing", cs_pend && (cyc == last_cs_cyc + LAT + 1) && (cs_if == if_ready), 1'b1);
        cs_pend = 1'b0;
        if (if_ready) begin
          if (if_q.size() == 0) chk1("if_ready_unexpected", 1'b1, 1'b0);
          else begin
            mt = if_q.pop_front();
            chk("if_rdata", if_rdata, mt.rdata);
          end
        end else begin
          if (dm_q.size() == 0) chk1("dm_ready_unexpected", 1'b1, 1'b0);
          else begin
            mt = dm_q.pop_front();
            chk("dm_rdata", dm_rdata, mt.rdata);
          end
        end
      end
      prev_cs = mem_cs;
      dm_req_prev = dm_req;
    end
  end

  task automatic push_if(input logic [31:0] addr);
    txn_t t;
    if_addr = addr;
    if_req = 1'b1;
    t.addr = addr; t.we = 1'b0; t.wdata = '0;
    t.rdata = ref_mem[addr[8:2]];
    if_q.push_back(t);
  endtask

  task automatic push_dm(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    txn_t t;
    dm_we = we; dm_addr = addr; dm_wdata = wd; dm_req = 1'b1;
    t.addr = addr; t.we = we; t.wdata = wd;
    if (we) begin
      ref_mem[addr[8:2]] = wd;
      t.rdata = last_dm_rdata;
    end else begin
      t.rdata = ref_mem[addr[8:2]];
      last_dm_rdata = t.rdata;
    end
    dm_q.push_back(t);
  endtask

  task automatic wait_if(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!if_ready && lat < 300);
    if (!if_ready) begin chk1("if_ready_timeout", 1'b0, 1'b1); lat = -1; end
  endtask

  task automatic wait_dm(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!dm_ready && lat < 300);
    if (!dm_ready) begin chk1("dm_ready_timeout", 1'b0, 1'b1); lat = -1; end
  endtask

  int l_a, l_b, nrdy;
  int if_lat, dm_lat, if_gap, dm_gap, l1;
  logic if_b2b, dm_b2b;
  logic [31:0] v, a1;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req1 = 1'b0; if_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
    last_dm_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_mem_cs", mem_cs, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_dm_ready", dm_ready, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_lat1_dm_ready", dm_ready1, 1'b0);
    rst = 1'b0;

    // single fetch
    push_if(32'h10);
    wait_if(l_a);
    if_req = 1'b0;
    chk("fetch_latency", 32'(l_a), 32'(LAT + 2));

    // simultaneous requests: DM first, IF next
    @(posedge clk); #1;
    push_dm(1'b0, 32'h140, 32'h0);
    push_if(32'h20);
    fork
      begin wait_dm(l_a); dm_req = 1'b0; end
      begin wait_if(l_b); if_req = 1'b0; end
    join
    chk("simul_dm_latency", 32'(l_a), 32'(LAT + 2));
    chk("simul_if_latency", 32'(l_b), 32'(2 * LAT + 5));

    // data write
    @(posedge clk); #1;
    push_dm(1'b1, 32'h108, 32'h12345678);
    wait_dm(l_a);
    dm_req = 1'b0;
    chk("write_latency", 32'(l_a), 32'(LAT + 2));

    // back-to-back fetch with req held high
    @(posedge clk); #1;
    push_if(32'h0);
    wait_if(l_a);
    push_if(32'h4);
    wait_if(l_b);
    if_req = 1'b0;
    chk("b2b_first_latency", 32'(l_a), 32'(LAT + 2));
    chk("b2b_second_latency", 32'(l_b), 32'(LAT + 3));
    chk("b2b_cs_spacing", 32'(last_cs_cyc - prev_cs_cyc), 32'(LAT + 3));

    // reset one cycle after mem_cs
    @(posedge clk); #1;
    push_if(32'h30);
    l_a = 0;
    do begin @(posedge clk); #1; l_a++; end while (!mem_cs && l_a < 20);
    chk1("rst_test_cs_seen", mem_cs, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b0;
    if_q.delete();
    dm_q.delete();
    last_dm_rdata = '0;
    @(posedge clk); #1;
    chk1("midrst_mem_cs", mem_cs, 1'b0);
    chk1("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_mem_wdata", mem_wdata, 32'h0);
    chk("midrst_if_rdata", if_rdata, 32'h0);
    chk("midrst_dm_rdata", dm_rdata, 32'h0);
    chk1("midrst_ready", if_ready | dm_ready, 1'b0);
    chk1("midrst_stall", stall_o, 1'b0);
    rst = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 2 * LAT + 6; i++) begin
      @(posedge clk); #1;
      if (if_ready | dm_ready) nrdy++;
    end
    chk("midrst_no_ready", 32'(nrdy), 32'h0);
    push_dm(1'b0, 32'h1F0, 32'h0);
    wait_dm(l_a);
    dm_req = 1'b0;
    chk("post_rst_latency", 32'(l_a), 32'(LAT + 2));

    // randomized traffic from both ports
    @(posedge clk); #1;
    fork
      begin
        if_b2b = 1'b0;
        for (int n = 0; n < 40; n++) begin
          if (!if_b2b) begin
            if_req = 1'b0;
            if_gap = $urandom_range(1, 4);
            repeat (if_gap) begin @(posedge clk); #1; end
          end
          push_if(32'($urandom_range(0, 63)) << 2);
          wait_if(if_lat);
          chk1("if_min_latency", if_lat >= LAT + 2, 1'b1);
          if_b2b = ($urandom_range(0, 3) == 0);
        end
        if_req = 1'b0;
      end
      begin
        dm_b2b = 1'b0;
        for (int n = 0; n < 40; n++) begin
          if (!dm_b2b) begin
            dm_req = 1'b0;
            dm_gap = $urandom_range(1, 6);
            repeat (dm_gap) begin @(posedge clk); #1; end
          end
          push_dm(1'($urandom_range(0, 1)), 32'h100 | (32'($urandom_range(0, 63)) << 2), $urandom);
          wait_dm(dm_lat);
          chk1("dm_latency_bound", (dm_lat >= LAT + 2) && (dm_lat <= 2 * LAT + 4), 1'b1);
          dm_b2b = ($urandom_range(0, 3) == 0);
        end
        dm_req = 1'b0;
      end
    join

    // LAT=1 instance: single DM reads
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      a1 = 32'($urandom_range(0, 255)) << 2;
      dm_addr1 = a1; dm_we1 = 1'b0; dm_req1 = 1'b1;
      l1 = 0;
      do begin @(posedge clk); #1; l1++; end while (!dm_ready1 && l1 < 20);
      chk("lat1_latency", 32'(l1), 32'h3);
      chk("lat1_rdata", dm_rdata1, a1 ^ K1);
      dm_req1 = 1'b0;
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", 32'(if_q.size() + dm_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-ported, fixed-latency unified memory shared by the pipeline's instruction-fetch port and MEM-stage data port. It sits between the IF/MEM stages and the memory. It grants one access at a time, with data accesses taking priority, and tracks the memory latency with a counter. It returns read data through registered response ports and drives a stall signal that freezes the PC and the pipeline latches while any access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `LAT`, 2: memory read latency in cycles, counted from the issue cycle. Legal range 1..15.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `if_req`  in  1  — instruction fetch request, read-only.
- `if_addr`  in  ADDR_W  — fetch address.
- `if_rdata`  out  DATA_W  — fetched instruction; registered.
- `if_ready`  out  1  — one-cycle completion pulse for the fetch.
- `dm_req`  in  1  — data request.
- `dm_we`  in  1  — 1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  — data address.
- `dm_wdata`  in  DATA_W  — write data.
- `dm_rdata`  out  DATA_W  — load data; registered.
- `dm_ready`  out  1  — one-cycle completion pulse for the data access.
- `mem_cs`  out  1  — memory chip select; one-cycle issue pulse.
- `mem_we`  out  1  — memory write enable; only meaningful with `mem_cs`.
- `mem_addr`  out  ADDR_W  — memory address; passed through unmodified.
- `mem_wdata`  out  DATA_W  — memory write data.
- `mem_rdata`  in  DATA_W  — memory read data; valid exactly `LAT` cycles after the `mem_cs` cycle.
- `stall_o`  out  1  — pipeline stall request.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `dm_req`, grant DM; else if `if_req`, grant IF.
  - On a grant, latch owner, address, write-enable (IF forces 0) and write data, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - Assert `mem_cs` for exactly one cycle, with `mem_we`/`mem_addr`/`mem_wdata` taken from the latched values.
  - Load the counter with `LAT`-1 and go to WAIT. Counter width is 4 bits.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter reads 0, `mem_rdata` is valid. On reads, capture it into the owner's rdata register. Go to RESP.
- RESP:
  - Pulse the owner's ready for one cycle, then return to IDLE.
  - Requests are not sampled in RESP.
- Writes:
  - The full latency is still observed.
  - `dm_ready` pulses at the same time offset as for a read.
  - `dm_rdata` is unchanged.
- Handshake rules:
  - A requester holds req and its attributes stable until it sees ready.
  - req still high in the cycle after ready is a new request.
  - Request inputs are sampled only in IDLE. Attribute changes after the grant are ignored.
- Request dropped mid-transaction: the transaction completes and ready still pulses. The requester must ignore it.
- Simultaneous requests: DM is served first and IF stays pending, so IF is served in the next IDLE. There is no starvation, because the pipeline stalls until DM completes and then drops `dm_req`.
- `stall_o` = (`if_req` & ~`if_ready`) | (`dm_req` & ~`dm_ready`). It is combinational from the inputs and the registered ready pulses.
- Reset:
  - Any state goes to IDLE and any outstanding transaction is abandoned.
  - All outputs are driven to 0, including `if_rdata`/`dm_rdata`, both ready pulses and the counter.
  - A `mem_rdata` return arriving after reset is ignored.

## Timing
- Request seen in IDLE at cycle T:
  - `mem_cs` high at T+1.
  - `mem_rdata` sampled at T+1+`LAT`.
  - ready and rdata valid at T+2+`LAT`.
- Per-access latency is `LAT`+2 cycles. Occupancy is `LAT`+3 cycles including IDLE, so the next grant is no earlier than T+3+`LAT`.
- `mem_cs`, `mem_we`, `mem_addr`, `mem_wdata`, the rdata outputs and the ready outputs are all registered.
- `mem_we` is 0 whenever `mem_cs` is 0. `mem_addr`/`mem_wdata` hold their last value outside ISSUE.
- With `LAT`=1, WAIT lasts exactly one cycle, because the counter loads 0.

## Test plan
- Single fetch, `LAT`=2:
  - Stimulus: `if_req`=1, `if_addr`=0x10 at cycle 1; memory returns 0xDEADBEEF at cycle 4.
  - Required: `mem_cs`=1, `mem_we`=0, `mem_addr`=0x10 at cycle 2; `if_ready`=1 with `if_rdata`=0xDEADBEEF at cycle 5; `stall_o`=1 for cycles 1–4 and 0 at cycle 5.
- Simultaneous requests:
  - Stimulus: `if_req`=1 (0x20) and `dm_req`=1 (read 0x40) at cycle 1.
  - Required: DM issued at cycle 2; `dm_ready` at cycle 5; IF granted in IDLE at cycle 6, issued at cycle 7, `if_ready` at cycle 10.
- Data write:
  - Stimulus: `dm_we`=1, `dm_addr`=0x8, `dm_wdata`=0x12345678.
  - Required: `mem_cs`=`mem_we`=1 with those values for exactly one cycle; `dm_ready` `LAT`+2 cycles after the request; `dm_rdata` unchanged.
- Back-to-back fetch:
  - Stimulus: `if_req` held high across two accesses to 0x0 then 0x4.
  - Required: second `mem_cs` exactly `LAT`+3 cycles after the first; two distinct `if_ready` pulses.
- Reset mid-WAIT:
  - Stimulus: assert `rst` one cycle after `mem_cs`.
  - Required: next cycle all outputs are 0 and the FSM is in IDLE; no ready pulse occurs; a fresh request afterwards completes normally with `LAT`+2 latency.
- `LAT`=1 parameter sweep:
  - Stimulus: single DM read.
  - Required: `dm_ready` exactly 3 cycles after the request cycle.
